// File: rtl/lsu_axi_bridge_if.sv
// rtl/lsu_axi_bridge_if.sv - LSU request/response bundle and AXI4-Lite bundle
interface lsu_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic [7:0]        rstrb;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic [DATA_W-1:0] wdata;
    logic [7:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic              err;

    modport master (
        output araddr, arvalid, rstrb, awaddr, awvalid, wdata, wstrb, wvalid,
        input  rdata, rvalid, wready, err
    );
    modport slave (
        input  araddr, arvalid, rstrb, awaddr, awvalid, wdata, wstrb, wvalid,
        output rdata, rvalid, wready, err
    );
endinterface

interface axi_lite_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arsize;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awsize;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arsize, arvalid, rready, awaddr, awsize, awvalid,
               wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
    modport slave (
        input  araddr, arsize, arvalid, rready, awaddr, awsize, awvalid,
               wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/lsu_axi_bridge.sv
// rtl/lsu_axi_bridge.sv - LSU load/store requests to single AXI4-Lite transactions
module lsu_axi_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    lsu_if.slave      lsu,
    axi_lite_if.master axi
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, RESP, GAP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [2:0]          arsize_q, arsize_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [2:0]          awsize_q, awsize_d;
    logic                awvalid_q, awvalid_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
    logic                lsu_rvalid_q, lsu_rvalid_d;
    logic                lsu_wready_q, lsu_wready_d;
    logic                lsu_err_q, lsu_err_d;
    logic                aw_hs, w_hs;

    function automatic logic [2:0] size_of(input logic [7:0] strb);
        case (strb)
            8'h01:   size_of = 3'd0;
            8'h03:   size_of = 3'd1;
            default: size_of = 3'd2;
        endcase
    endfunction

    assign aw_hs = awvalid_q & axi.awready;
    assign w_hs  = wvalid_q & axi.wready;

    always_comb begin
        state_d      = state_q;
        araddr_d     = araddr_q;
        arsize_d     = arsize_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awaddr_d     = awaddr_q;
        awsize_d     = awsize_q;
        awvalid_d    = awvalid_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        lsu_rdata_d  = lsu_rdata_q;
        lsu_rvalid_d = 1'b0;
        lsu_wready_d = 1'b0;
        lsu_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (lsu.arvalid) begin
                    araddr_d  = lsu.araddr;
                    arsize_d  = size_of(lsu.rstrb);
                    arvalid_d = 1'b1;
                    state_d   = RD_A;
                end else if (lsu.awvalid && lsu.wvalid) begin
                    awaddr_d  = lsu.awaddr;
                    awsize_d  = size_of(lsu.wstrb);
                    // Misaligned strobes that spill past lane 3 are simply truncated.
                    wstrb_d   = lsu.wstrb[3:0] << lsu.awaddr[1:0];
                    wdata_d   = lsu.wdata << {lsu.awaddr[1:0], 3'b000};
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_AW;
                end
            end
            RD_A: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_D;
                end
            end
            RD_D: begin
                if (axi.rvalid) begin
                    rready_d     = 1'b0;
                    lsu_rdata_d  = axi.rdata;
                    lsu_rvalid_d = 1'b1;
                    lsu_err_d    = |axi.rresp;
                    state_d      = RESP;
                end
            end
            WR_AW: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = WR_B;
                end
            end
            WR_B: begin
                if (axi.bvalid) begin
                    bready_d     = 1'b0;
                    lsu_wready_d = 1'b1;
                    lsu_err_d    = |axi.bresp;
                    state_d      = RESP;
                end
            end
            RESP:    state_d = GAP;
            // The LSU still holds its request level here; let it fall before re-arbitrating.
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            araddr_q     <= '0;
            arsize_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awaddr_q     <= '0;
            awsize_q     <= '0;
            awvalid_q    <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            lsu_rdata_q  <= '0;
            lsu_rvalid_q <= 1'b0;
            lsu_wready_q <= 1'b0;
            lsu_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            arsize_q     <= arsize_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awaddr_q     <= awaddr_d;
            awsize_q     <= awsize_d;
            awvalid_q    <= awvalid_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            lsu_rdata_q  <= lsu_rdata_d;
            lsu_rvalid_q <= lsu_rvalid_d;
            lsu_wready_q <= lsu_wready_d;
            lsu_err_q    <= lsu_err_d;
        end
    end

    assign axi.araddr  = araddr_q;
    assign axi.arsize  = arsize_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
    assign axi.awaddr  = awaddr_q;
    assign axi.awsize  = awsize_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

    assign lsu.rdata   = lsu_rdata_q;
    assign lsu.rvalid  = lsu_rvalid_q;
    assign lsu.wready  = lsu_wready_q;
    assign lsu.err     = lsu_err_q;
endmodule
